// File: rtl/uart_rx_if.sv
// uart_rx_if: bundles the serial line, parity selection and the received-byte
// status bus of uart_rx.
//   RXD          serial line, idle high, asynchronous to the system clock
//   PARITY_MODE  0 = even parity, 1 = odd parity
//   DOUT         last received byte
//   VALID        1-cycle strobe: DOUT / PARITY_ERR / FRAME_ERR updated
//   PARITY_ERR   parity mismatch on the last frame
//   FRAME_ERR    stop bit sampled low on the last frame
//   BUSY         receiver is inside a frame (start edge seen, not yet idle)
// modport master: the receiver (drives the status bus, reads line and mode).
// modport slave:  the line driver / byte consumer side.
interface uart_rx_if;
    logic       RXD;
    logic       PARITY_MODE;
    logic [7:0] DOUT;
    logic       VALID;
    logic       PARITY_ERR;
    logic       FRAME_ERR;
    logic       BUSY;

    modport master (
        input  RXD, PARITY_MODE,
        output DOUT, VALID, PARITY_ERR, FRAME_ERR, BUSY
    );

    modport slave (
        output RXD, PARITY_MODE,
        input  DOUT, VALID, PARITY_ERR, FRAME_ERR, BUSY
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8-bit serial receiver, frame = start + 8 data (LSB first) +
// parity + 1 stop. RXD is synchronised internally; a free-running 16x
// oversampling tick (cleared while idle) places every sample at mid-bit.
//   CLK  system clock, rising edge
//   RST  asynchronous reset, active high
//   bus  uart_rx_if.master: RXD, PARITY_MODE in; DOUT, VALID, PARITY_ERR,
//        FRAME_ERR, BUSY out (all outputs registered)
module uart_rx #(
    parameter int unsigned CLK_FREQ   = 125_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic      CLK,
    input  logic      RST,
    uart_rx_if.master bus
);
    localparam int unsigned DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t        state;
    logic          rx_meta, rxs, rxs_prev;
    logic [1:0]    fill;
    logic          armed;
    logic [CW-1:0] cnt;
    logic [3:0]    idx;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          pmode, perr;
    logic [7:0]    dout_r;
    logic          valid_r, perr_r, ferr_r, busy_r;
    logic          tick, sample, fall;

    // The sync flops reset to 1, so their own reset value must not count as
    // the "1 seen first" that arms start detection: arming waits until the
    // chain has been refilled from the real line and shows a 1.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
            fill     <= '0;
            armed    <= 1'b0;
        end else begin
            rx_meta  <= bus.RXD;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
            fill     <= {fill[0], 1'b1};
            if (fill[1] && rxs)
                armed <= 1'b1;
        end
    end

    assign fall   = armed && rxs_prev && !rxs;
    assign tick   = (state != S_IDLE) && (cnt == CW'(DIV - 1));
    assign sample = tick && (idx == 4'd7);

    // Tick divider and tick index are held at zero in IDLE so the first
    // sample lands exactly 8 ticks after the detected start edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
            idx <= '0;
        end else if (state == S_IDLE) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= idx + 4'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            pmode   <= 1'b0;
            perr    <= 1'b0;
            dout_r  <= '0;
            valid_r <= 1'b0;
            perr_r  <= 1'b0;
            ferr_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fall) begin
                        state  <= S_START;
                        busy_r <= 1'b1;
                    end
                end
                S_START: begin
                    if (sample) begin
                        if (rxs) begin
                            state  <= S_IDLE;
                            busy_r <= 1'b0;
                        end else begin
                            pmode   <= bus.PARITY_MODE;
                            bit_cnt <= '0;
                            state   <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (sample) begin
                        shreg <= {rxs, shreg[7:1]};
                        if (bit_cnt == 3'd7)
                            state <= S_PARITY;
                        else
                            bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                S_PARITY: begin
                    if (sample) begin
                        perr  <= ((^shreg) ^ rxs) != pmode;
                        state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (sample) begin
                        dout_r  <= shreg;
                        valid_r <= 1'b1;
                        perr_r  <= perr;
                        ferr_r  <= ~rxs;
                        if (rxs) begin
                            state  <= S_IDLE;
                            busy_r <= 1'b0;
                        end else begin
                            state <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    if (rxs) begin
                        state  <= S_IDLE;
                        busy_r <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.DOUT       = dout_r;
    assign bus.VALID      = valid_r;
    assign bus.PARITY_ERR = perr_r;
    assign bus.FRAME_ERR  = ferr_r;
    assign bus.BUSY       = busy_r;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames for uart_rx at 16 clocks/bit,
// checked against a frame-level reference model.
module tb_uart_rx;
    localparam int unsigned CLK_FREQ = 1_600_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int unsigned BITCLK   = 16;
    // start-bit drive -> VALID seen: 2 sync + 1 edge + 168 ticks to stop mid-bit
    localparam int LAT = 171;

    logic CLK = 1'b0;
    logic RST;
    uart_rx_if bus ();

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(16)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // VALID capture (recording only)
    int         v_cyc[$];
    logic [7:0] v_d[$];
    logic       v_pe[$];
    logic       v_fe[$];
    always @(negedge CLK) begin
        if (bus.VALID === 1'b1) begin
            v_cyc.push_back(cyc);
            v_d.push_back(bus.DOUT);
            v_pe.push_back(bus.PARITY_ERR);
            v_fe.push_back(bus.FRAME_ERR);
        end
    end

    // Reference model: frame-level parity rule from bit counts.
    function automatic logic model_perr(input logic [7:0] d, input logic p, input logic mode);
        int ones;
        ones = $countones(d) + (p ? 1 : 0);
        return ((ones % 2) == 1) != mode;
    endfunction

    function automatic logic good_parity(input logic [7:0] d, input logic mode);
        return (($countones(d) % 2) == 1) != mode;
    endfunction

    task automatic clear_capture();
        v_cyc.delete(); v_d.delete(); v_pe.delete(); v_fe.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Drives one frame starting at the current negedge; returns at the negedge
    // where the next frame could start. RXD is left at the stop-bit level.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input logic flip, output int start_cyc);
        logic [10:0] f;
        f = {s, p, d, 1'b0};
        start_cyc = cyc;
        for (int i = 0; i < 11; i++) begin
            bus.RXD = f[i];
            if (flip && i == 3) bus.PARITY_MODE = ~bus.PARITY_MODE;
            repeat (BITCLK) @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        idle(3);
        checks++; if (bus.DOUT !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", bus.DOUT); end
        checks++; if (bus.VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.VALID); end
        checks++; if (bus.PARITY_ERR !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", bus.PARITY_ERR); end
        checks++; if (bus.FRAME_ERR !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", bus.FRAME_ERR); end
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.BUSY); end
        RST = 1'b0;
        clear_capture();
        idle(10);
        checks++; if (v_cyc.size() != 0 || bus.BUSY !== 1'b0) begin errors++; $display("FAIL post_reset_idle: valids %0d busy %b expected 0 0", v_cyc.size(), bus.BUSY); end
    endtask

    task automatic test_even_a5();
        int st;
        logic epe;
        clear_capture();
        bus.PARITY_MODE = 1'b0;
        epe = model_perr(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, st);
        idle(4);
        checks++; if (v_cyc.size() != 1) begin errors++; $display("FAIL a5_count: got %0d expected 1", v_cyc.size()); end
        if (v_cyc.size() >= 1) begin
            checks++; if (v_d[0] !== 8'hA5) begin errors++; $display("FAIL a5_dout: got %h expected a5", v_d[0]); end
            checks++; if (v_pe[0] !== epe) begin errors++; $display("FAIL a5_perr: got %b expected %b", v_pe[0], epe); end
            checks++; if (v_fe[0] !== 1'b0) begin errors++; $display("FAIL a5_ferr: got %b expected 0", v_fe[0]); end
            checks++; if (v_cyc[0] - st != LAT) begin errors++; $display("FAIL a5_latency: got %0d expected %0d", v_cyc[0] - st, LAT); end
        end
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL a5_busy_after: got %b expected 0", bus.BUSY); end
    endtask

    task automatic test_odd_parity();
        int st;
        logic e0, e1;
        clear_capture();
        bus.PARITY_MODE = 1'b1;
        e0 = model_perr(8'h3C, 1'b0, 1'b1);
        e1 = model_perr(8'h01, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, st);
        idle(6);
        send_frame(8'h01, 1'b0, 1'b1, 1'b0, st);
        idle(4);
        checks++; if (v_cyc.size() != 2) begin errors++; $display("FAIL odd_count: got %0d expected 2", v_cyc.size()); end
        if (v_cyc.size() == 2) begin
            checks++; if (v_d[0] !== 8'h3C || v_pe[0] !== e0) begin errors++; $display("FAIL odd_frame0: got %h/%b expected 3c/%b", v_d[0], v_pe[0], e0); end
            checks++; if (v_d[1] !== 8'h01 || v_pe[1] !== e1) begin errors++; $display("FAIL odd_frame1: got %h/%b expected 01/%b", v_d[1], v_pe[1], e1); end
        end
    endtask

    task automatic test_break();
        int st;
        int n;
        clear_capture();
        bus.PARITY_MODE = 1'b0;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, st);
        idle(40);
        checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL break_busy_low_line: got %b expected 1", bus.BUSY); end
        bus.RXD = 1'b1;
        n = 0;
        while (n < 10 && bus.BUSY === 1'b1) begin
            @(negedge CLK);
            n++;
        end
        checks++; if (n != 3) begin errors++; $display("FAIL break_busy_fall: got %0d clks expected 3", n); end
        idle(20);
        checks++; if (v_cyc.size() != 1) begin errors++; $display("FAIL break_count: got %0d expected 1", v_cyc.size()); end
        if (v_cyc.size() >= 1) begin
            checks++; if (v_fe[0] !== 1'b1) begin errors++; $display("FAIL break_ferr: got %b expected 1", v_fe[0]); end
            checks++; if (v_d[0] !== 8'h55 || v_pe[0] !== model_perr(8'h55, 1'b0, 1'b0)) begin errors++; $display("FAIL break_dout: got %h/%b expected 55/%b", v_d[0], v_pe[0], model_perr(8'h55, 1'b0, 1'b0)); end
        end
    endtask

    task automatic test_glitch();
        int last_high;
        clear_capture();
        last_high = 0;
        bus.RXD = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge CLK);
            if (n == 5) bus.RXD = 1'b1;
            if (bus.BUSY === 1'b1) last_high = n;
        end
        checks++; if (last_high != 10) begin errors++; $display("FAIL glitch_busy_window: got last high at %0d expected 10", last_high); end
        idle(200);
        checks++; if (v_cyc.size() != 0 || bus.BUSY !== 1'b0) begin errors++; $display("FAIL glitch_no_valid: got %0d valids busy %b expected 0 0", v_cyc.size(), bus.BUSY); end
    endtask

    task automatic test_back_to_back();
        int s0, s1;
        clear_capture();
        bus.PARITY_MODE = 1'b0;
        send_frame(8'h00, good_parity(8'h00, 1'b0), 1'b1, 1'b0, s0);
        send_frame(8'hFF, good_parity(8'hFF, 1'b0), 1'b1, 1'b0, s1);
        idle(6);
        checks++; if (v_cyc.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", v_cyc.size()); end
        if (v_cyc.size() == 2) begin
            checks++; if (v_cyc[1] - v_cyc[0] != 176) begin errors++; $display("FAIL b2b_spacing: got %0d expected 176", v_cyc[1] - v_cyc[0]); end
            checks++; if (v_d[0] !== 8'h00 || v_d[1] !== 8'hFF) begin errors++; $display("FAIL b2b_data: got %h %h expected 00 ff", v_d[0], v_d[1]); end
            checks++; if ({v_pe[0], v_fe[0], v_pe[1], v_fe[1]} !== 4'b0000) begin errors++; $display("FAIL b2b_errs: got %b%b%b%b expected 0000", v_pe[0], v_fe[0], v_pe[1], v_fe[1]); end
        end
    endtask

    task automatic test_reset_midframe();
        logic [10:0] f;
        int st;
        clear_capture();
        bus.PARITY_MODE = 1'b0;
        f = {1'b1, good_parity(8'h81, 1'b0), 8'h81, 1'b0};
        for (int i = 0; i < 6; i++) begin
            bus.RXD = f[i];
            repeat (i == 5 ? BITCLK / 2 : BITCLK) @(negedge CLK);
        end
        checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", bus.BUSY); end
        RST = 1'b1;
        idle(2);
        checks++; if ({bus.DOUT, bus.VALID, bus.PARITY_ERR, bus.FRAME_ERR, bus.BUSY} !== 12'h000) begin errors++; $display("FAIL midrst_outputs: got %h %b%b%b%b expected 00 0000", bus.DOUT, bus.VALID, bus.PARITY_ERR, bus.FRAME_ERR, bus.BUSY); end
        bus.RXD = 1'b1;
        idle(2);
        RST = 1'b0;
        idle(10);
        send_frame(8'h7E, good_parity(8'h7E, 1'b0), 1'b1, 1'b0, st);
        idle(6);
        checks++; if (v_cyc.size() != 1) begin errors++; $display("FAIL midrst_count: got %0d expected 1", v_cyc.size()); end
        if (v_cyc.size() >= 1) begin
            checks++; if (v_d[0] !== 8'h7E || v_pe[0] !== 1'b0 || v_fe[0] !== 1'b0) begin errors++; $display("FAIL midrst_dout: got %h/%b/%b expected 7e/0/0", v_d[0], v_pe[0], v_fe[0]); end
        end
    endtask

    task automatic test_random();
        logic [7:0] e_d[$];
        logic       e_pe[$];
        logic       e_fe[$];
        int         e_st[$];
        logic [7:0] d;
        logic       p, s, mode, flip;
        int         st;
        clear_capture();
        for (int k = 0; k < 24; k++) begin
            d    = 8'($urandom_range(0, 255));
            mode = 1'($urandom_range(0, 1));
            flip = 1'($urandom_range(0, 1));
            p    = ($urandom_range(0, 2) == 0) ? ~good_parity(d, mode) : good_parity(d, mode);
            s    = ($urandom_range(0, 3) != 0);
            bus.PARITY_MODE = mode;
            e_d.push_back(d);
            e_pe.push_back(model_perr(d, p, mode));
            e_fe.push_back(~s);
            send_frame(d, p, s, flip, st);
            e_st.push_back(st);
            if (!s) begin
                idle($urandom_range(0, 20));
                bus.RXD = 1'b1;
                idle(4 + $urandom_range(0, 6));
            end else begin
                idle($urandom_range(0, 8));
            end
        end
        idle(10);
        checks++; if (v_cyc.size() != e_d.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", v_cyc.size(), e_d.size()); end
        for (int k = 0; k < e_d.size() && k < v_cyc.size(); k++) begin
            checks++;
            if (v_d[k] !== e_d[k] || v_pe[k] !== e_pe[k] || v_fe[k] !== e_fe[k] || v_cyc[k] - e_st[k] != LAT) begin
                errors++;
                $display("FAIL rand_frame%0d: got d=%h pe=%b fe=%b lat=%0d expected d=%h pe=%b fe=%b lat=%0d",
                         k, v_d[k], v_pe[k], v_fe[k], v_cyc[k] - e_st[k], e_d[k], e_pe[k], e_fe[k], LAT);
            end
        end
    endtask

    initial begin
        bus.RXD = 1'b1;
        bus.PARITY_MODE = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        test_reset();
        test_even_a5();
        test_odd_parity();
        test_break();
        test_glitch();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
